// File: rtl/fifo_umbrales_if.sv
// Bus bundle for fifo_umbrales: write/read handshake, threshold inputs and status outputs.
interface fifo_umbrales_if #(
  parameter int DATA_WIDTH   = 6,
  parameter int ADDR_WIDTH   = 2,
  parameter int UMBRAL_WIDTH = 4
);
  logic                    wr_enable;
  logic [DATA_WIDTH-1:0]   data_in;
  logic                    rd_enable;
  logic [UMBRAL_WIDTH-1:0] umbral_high;
  logic [UMBRAL_WIDTH-1:0] umbral_low;
  logic [DATA_WIDTH-1:0]   data_out;
  logic                    valid_out;
  logic                    empty;
  logic                    full;
  logic                    almost_full;
  logic                    almost_empty;
  logic                    error;
  logic [ADDR_WIDTH:0]     count;

  modport master (
    output wr_enable, data_in, rd_enable, umbral_high, umbral_low,
    input  data_out, valid_out, empty, full, almost_full, almost_empty, error, count
  );

  modport slave (
    input  wr_enable, data_in, rd_enable, umbral_high, umbral_low,
    output data_out, valid_out, empty, full, almost_full, almost_empty, error, count
  );
endinterface

// File: rtl/fifo_umbrales.sv
// Circular-buffer FIFO with programmable almost-full/almost-empty thresholds.
// Define FIFO_UMBRALES_STICKY_ERROR_EN to make error latch until reset; otherwise it is a one-cycle pulse.
module fifo_umbrales #(
  parameter int DATA_WIDTH   = 6,
  parameter int ADDR_WIDTH   = 2,
  parameter int UMBRAL_WIDTH = 4
) (
  input  logic            clk,
  input  logic            reset_L,
  fifo_umbrales_if.slave  bus
);

  localparam int                  DEPTH_INT = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH     = DEPTH_INT[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0]   mem [DEPTH_INT];
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [ADDR_WIDTH-1:0]   rd_ptr;
  logic [ADDR_WIDTH:0]     count;
  logic [DATA_WIDTH-1:0]   data_out;
  logic                    valid_out;
  logic                    error;

  logic                    full;
  logic                    empty;
  logic                    wr_accept;
  logic                    rd_accept;
  logic                    err_event;
  logic [UMBRAL_WIDTH-1:0] count_ext;

  assign full      = (count == DEPTH);
  assign empty     = (count == '0);
  assign count_ext = UMBRAL_WIDTH'(count);

  // A read frees a slot in the same edge, so a full FIFO still accepts a write paired with a read.
  assign wr_accept = bus.wr_enable && (!full || bus.rd_enable);
  assign rd_accept = bus.rd_enable && !empty;
  assign err_event = (bus.wr_enable && full && !bus.rd_enable) || (bus.rd_enable && empty);

  // Storage is left uncleared by reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_accept) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
      valid_out <= rd_accept;
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
`ifdef FIFO_UMBRALES_STICKY_ERROR_EN
      error <= error | err_event;
`else
      error <= err_event;
`endif
    end
  end

  assign bus.data_out     = data_out;
  assign bus.valid_out    = valid_out;
  assign bus.error        = error;
  assign bus.count        = count;
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_full  = (count_ext >= bus.umbral_high);
  assign bus.almost_empty = (count_ext <= bus.umbral_low);

endmodule

// File: tb/tb_fifo_umbrales.sv
// Randomized and directed checks of fifo_umbrales against a queue-based reference model.
module tb_fifo_umbrales;

  localparam int DW = 6;
  localparam int AW = 2;
  localparam int UW = 4;
  localparam int DEPTH = 4;

  logic clk;
  logic reset_L;

  fifo_umbrales_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .UMBRAL_WIDTH(UW)) bus ();

  fifo_umbrales #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .UMBRAL_WIDTH(UW)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_valid;
  logic          m_err;

  task automatic model_clear();
    q.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.wr_enable = 1'b0;
    bus.rd_enable = 1'b0;
    bus.data_in   = '0;
    reset_L = 1'b0;
    model_clear();
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  // One clock of stimulus; the model applies the FIFO rules to its queue at the same edge.
  task automatic cycle(input logic wr, input logic rd, input logic [DW-1:0] din);
    int  n;
    bit  ev;
    @(negedge clk);
    bus.wr_enable = wr;
    bus.rd_enable = rd;
    bus.data_in   = din;
    @(posedge clk);
    n  = q.size();
    ev = (wr && n == DEPTH && !rd) || (rd && n == 0);
    if (rd && n > 0) begin
      m_dout  = q.pop_front();
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (wr && (n < DEPTH || rd)) q.push_back(din);
`ifdef FIFO_UMBRALES_STICKY_ERROR_EN
    m_err = m_err | ev;
`else
    m_err = ev;
`endif
    #1;
  endtask

  task automatic test_reset();
    bus.umbral_high = 4'd3;
    bus.umbral_low  = 4'd1;
    do_reset();
    #1;
    checks++; if (bus.count !== 3'd0) $display("[TB] FAIL reset_count: got %0d expected 0", bus.count); else passes++;
    checks++; if (bus.empty !== 1'b1) $display("[TB] FAIL reset_empty: got %b expected 1", bus.empty); else passes++;
    checks++; if (bus.full !== 1'b0) $display("[TB] FAIL reset_full: got %b expected 0", bus.full); else passes++;
    checks++; if (bus.valid_out !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", bus.valid_out); else passes++;
    checks++; if (bus.error !== 1'b0) $display("[TB] FAIL reset_error: got %b expected 0", bus.error); else passes++;
    checks++; if (bus.data_out !== 6'h00) $display("[TB] FAIL reset_data_out: got %h expected 00", bus.data_out); else passes++;
    checks++; if (bus.almost_empty !== 1'b1) $display("[TB] FAIL reset_almost_empty: got %b expected 1", bus.almost_empty); else passes++;
    checks++; if (bus.almost_full !== 1'b0) $display("[TB] FAIL reset_almost_full: got %b expected 0", bus.almost_full); else passes++;
  endtask

  task automatic test_fill_threshold();
    bus.umbral_high = 4'd3;
    do_reset();
    cycle(1'b1, 1'b0, 6'h01);
    cycle(1'b1, 1'b0, 6'h02);
    checks++; if (bus.almost_full !== 1'b0) $display("[TB] FAIL fill2_almost_full: got %b expected 0", bus.almost_full); else passes++;
    cycle(1'b1, 1'b0, 6'h03);
    checks++; if (bus.count !== 3'd3) $display("[TB] FAIL fill_count: got %0d expected 3", bus.count); else passes++;
    checks++; if (bus.almost_full !== 1'b1) $display("[TB] FAIL fill_almost_full: got %b expected 1", bus.almost_full); else passes++;
    checks++; if (bus.full !== 1'b0) $display("[TB] FAIL fill_full: got %b expected 0", bus.full); else passes++;
    checks++; if (bus.error !== 1'b0) $display("[TB] FAIL fill_error: got %b expected 0", bus.error); else passes++;
  endtask

  task automatic test_overflow();
    logic [DW-1:0] expect_words [4];
    expect_words = '{6'h01, 6'h02, 6'h03, 6'h04};
    cycle(1'b1, 1'b0, 6'h04);
    checks++; if (bus.full !== 1'b1) $display("[TB] FAIL ovf_full: got %b expected 1", bus.full); else passes++;
    cycle(1'b1, 1'b0, 6'h3F);
    checks++; if (bus.count !== 3'd4) $display("[TB] FAIL ovf_count: got %0d expected 4", bus.count); else passes++;
    checks++; if (bus.error !== 1'b1) $display("[TB] FAIL ovf_error: got %b expected 1", bus.error); else passes++;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 6'h00);
      checks++; if (bus.data_out !== expect_words[i]) $display("[TB] FAIL ovf_read%0d: got %h expected %h", i, bus.data_out, expect_words[i]); else passes++;
      checks++; if (bus.valid_out !== 1'b1) $display("[TB] FAIL ovf_valid%0d: got %b expected 1", i, bus.valid_out); else passes++;
      checks++; if (bus.error !== m_err) $display("[TB] FAIL ovf_err_after%0d: got %b expected %b", i, bus.error, m_err); else passes++;
    end
    checks++; if (bus.empty !== 1'b1) $display("[TB] FAIL ovf_drained_empty: got %b expected 1", bus.empty); else passes++;
  endtask

  task automatic test_full_rw();
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 6'(16 + i));
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1, 6'h2A);
      checks++; if (bus.count !== 3'd4) $display("[TB] FAIL rw_count%0d: got %0d expected 4", i, bus.count); else passes++;
      checks++; if (bus.error !== 1'b0) $display("[TB] FAIL rw_error%0d: got %b expected 0", i, bus.error); else passes++;
      checks++; if (bus.valid_out !== 1'b1) $display("[TB] FAIL rw_valid%0d: got %b expected 1", i, bus.valid_out); else passes++;
      checks++; if (bus.data_out !== m_dout) $display("[TB] FAIL rw_data%0d: got %h expected %h", i, bus.data_out, m_dout); else passes++;
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 6'h00);
      checks++; if (bus.data_out !== 6'h2A) $display("[TB] FAIL rw_drain%0d: got %h expected 2a", i, bus.data_out); else passes++;
    end
  endtask

  task automatic test_underflow();
    do_reset();
    cycle(1'b0, 1'b1, 6'h00);
    checks++; if (bus.valid_out !== 1'b0) $display("[TB] FAIL udf_valid: got %b expected 0", bus.valid_out); else passes++;
    checks++; if (bus.error !== 1'b1) $display("[TB] FAIL udf_error: got %b expected 1", bus.error); else passes++;
    checks++; if (bus.data_out !== 6'h00) $display("[TB] FAIL udf_data_out: got %h expected 00", bus.data_out); else passes++;
    cycle(1'b1, 1'b1, 6'h11);
    checks++; if (bus.count !== 3'd1) $display("[TB] FAIL udf_rw_count: got %0d expected 1", bus.count); else passes++;
    checks++; if (bus.error !== 1'b1) $display("[TB] FAIL udf_rw_error: got %b expected 1", bus.error); else passes++;
    checks++; if (bus.valid_out !== 1'b0) $display("[TB] FAIL udf_rw_valid: got %b expected 0", bus.valid_out); else passes++;
    cycle(1'b0, 1'b0, 6'h00);
    checks++; if (bus.error !== m_err) $display("[TB] FAIL udf_idle_error: got %b expected %b", bus.error, m_err); else passes++;
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(1'b1, 1'b0, 6'h07);
    cycle(1'b1, 1'b0, 6'h08);
    cycle(1'b0, 1'b1, 6'h00);
    @(negedge clk);
    bus.wr_enable = 1'b0;
    bus.rd_enable = 1'b0;
    #2;
    reset_L = 1'b0;
    #1;
    checks++; if (bus.count !== 3'd0) $display("[TB] FAIL areset_count: got %0d expected 0", bus.count); else passes++;
    checks++; if (bus.empty !== 1'b1) $display("[TB] FAIL areset_empty: got %b expected 1", bus.empty); else passes++;
    checks++; if (bus.valid_out !== 1'b0) $display("[TB] FAIL areset_valid: got %b expected 0", bus.valid_out); else passes++;
    checks++; if (bus.error !== 1'b0) $display("[TB] FAIL areset_error: got %b expected 0", bus.error); else passes++;
    model_clear();
    @(negedge clk);
    reset_L = 1'b1;
    cycle(1'b1, 1'b0, 6'h15);
    cycle(1'b0, 1'b1, 6'h00);
    checks++; if (bus.data_out !== 6'h15) $display("[TB] FAIL areset_readback: got %h expected 15", bus.data_out); else passes++;
    checks++; if (bus.empty !== 1'b1) $display("[TB] FAIL areset_readback_empty: got %b expected 1", bus.empty); else passes++;
  endtask

  task automatic test_umbrales();
    bus.umbral_low  = 4'd1;
    bus.umbral_high = 4'd3;
    do_reset();
    cycle(1'b1, 1'b0, 6'h01);
    cycle(1'b1, 1'b0, 6'h02);
    checks++; if (bus.almost_empty !== 1'b0) $display("[TB] FAIL ae_at2: got %b expected 0", bus.almost_empty); else passes++;
    cycle(1'b0, 1'b1, 6'h00);
    checks++; if (bus.almost_empty !== 1'b1) $display("[TB] FAIL ae_at1: got %b expected 1", bus.almost_empty); else passes++;
    bus.umbral_low = 4'd0;
    #1;
    checks++; if (bus.almost_empty !== 1'b0) $display("[TB] FAIL ae_low0: got %b expected 0", bus.almost_empty); else passes++;
    bus.umbral_high = 4'd0;
    #1;
    checks++; if (bus.almost_full !== 1'b1) $display("[TB] FAIL af_high0: got %b expected 1", bus.almost_full); else passes++;
    bus.umbral_high = 4'd5;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 6'(i));
    checks++; if (bus.full !== 1'b1) $display("[TB] FAIL af_high5_full: got %b expected 1", bus.full); else passes++;
    checks++; if (bus.almost_full !== 1'b0) $display("[TB] FAIL af_high5: got %b expected 0", bus.almost_full); else passes++;
    bus.umbral_high = 4'd4;
    #1;
    checks++; if (bus.almost_full !== 1'b1) $display("[TB] FAIL af_high4: got %b expected 1", bus.almost_full); else passes++;
  endtask

  task automatic test_random();
    logic wr, rd;
    logic [DW-1:0] din;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      wr  = 1'($urandom_range(0, 99) < 55);
      rd  = 1'($urandom_range(0, 99) < 45);
      din = DW'($urandom);
      if ($urandom_range(0, 15) == 0) bus.umbral_high = UW'($urandom_range(0, 6));
      if ($urandom_range(0, 15) == 0) bus.umbral_low  = UW'($urandom_range(0, 5));
      cycle(wr, rd, din);
      checks++; if (bus.count !== q.size()) $display("[TB] FAIL rnd_count@%0d: got %0d expected %0d", i, bus.count, q.size()); else passes++;
      checks++; if (bus.valid_out !== m_valid) $display("[TB] FAIL rnd_valid@%0d: got %b expected %b", i, bus.valid_out, m_valid); else passes++;
      checks++; if (bus.data_out !== m_dout) $display("[TB] FAIL rnd_data@%0d: got %h expected %h", i, bus.data_out, m_dout); else passes++;
      checks++; if (bus.error !== m_err) $display("[TB] FAIL rnd_error@%0d: got %b expected %b", i, bus.error, m_err); else passes++;
      checks++; if (bus.empty !== (q.size() == 0)) $display("[TB] FAIL rnd_empty@%0d: got %b expected %b", i, bus.empty, q.size() == 0); else passes++;
      checks++; if (bus.full !== (q.size() == DEPTH)) $display("[TB] FAIL rnd_full@%0d: got %b expected %b", i, bus.full, q.size() == DEPTH); else passes++;
      checks++; if (bus.almost_full !== (q.size() >= int'(bus.umbral_high))) $display("[TB] FAIL rnd_almost_full@%0d: got %b expected %b", i, bus.almost_full, q.size() >= int'(bus.umbral_high)); else passes++;
      checks++; if (bus.almost_empty !== (q.size() <= int'(bus.umbral_low))) $display("[TB] FAIL rnd_almost_empty@%0d: got %b expected %b", i, bus.almost_empty, q.size() <= int'(bus.umbral_low)); else passes++;
    end
  endtask

  initial begin
    reset_L         = 1'b0;
    bus.wr_enable   = 1'b0;
    bus.rd_enable   = 1'b0;
    bus.data_in     = '0;
    bus.umbral_high = 4'd3;
    bus.umbral_low  = 4'd1;
    model_clear();
    test_reset();
    test_fill_threshold();
    test_overflow();
    test_full_rw();
    test_underflow();
    test_async_reset();
    test_umbrales();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
